fir_ss_feeder: RTL

FIR_SS_FEEDER -- requirements
Module: fir_ss_feeder

---
 rtl/fir_pkg.sv | 7 +
 rtl/fir_stream_fifo.sv | 38 +++
 rtl/fir_ss_feeder.sv | 92 +++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding and constants for the FIR stream feeder
package fir_pkg;
  localparam int BYTES_PER_SAMPLE = 4;
  localparam int ADDR_WIDTH_DEF = 12;
  localparam int DATA_WIDTH_DEF = 32;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} feed_state_t;
endpackage

// File: rtl/fir_stream_fifo.sv
// fir_stream_fifo: synchronous FIFO buffering returned samples ahead of the stream port
module fir_stream_fifo #(
  parameter int DW = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic [DW-1:0] o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_din;
        r_wp <= r_wp + 1'b1;
      end
      if (i_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end
  assign o_dout = r_mem[r_rp];
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
endmodule

// File: rtl/fir_ss_feeder.sv
// fir_ss_feeder: streams a block of samples from sample memory to the FIR AXI-Stream slave
module fir_ss_feeder
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int pDATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BUF_DEPTH = 2
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   start,
  input  logic [31:0]            length,
  input  logic [pADDR_WIDTH-1:0] base_addr,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            sent_cnt,
  output logic                   mem_EN,
  output logic [pADDR_WIDTH-1:0] mem_A,
  input  logic [pDATA_WIDTH-1:0] mem_Do,
  output logic                   ss_tvalid,
  output logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tlast,
  input  logic                   ss_tready
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  feed_state_t r_state;
  logic [31:0] r_len, r_rd_cnt, r_sent;
  logic [pADDR_WIDTH-1:0] r_addr;
  logic r_inflight, r_done;
  logic w_pop, w_push, w_issue, w_full, w_empty;
  logic [pDATA_WIDTH-1:0] w_head;
  logic [CW-1:0] w_cnt, w_occ;
  assign w_pop = ss_tvalid && ss_tready;
  assign w_push = r_inflight && (!w_full || w_pop);
  // a beat leaving this cycle frees the slot the read issued now will land in
  assign w_occ = w_cnt - CW'(w_pop) + CW'(r_inflight);
  assign w_issue = (r_state == ST_RUN) && (w_occ < CW'(BUF_DEPTH));
  assign busy = r_state != ST_IDLE;
  assign done = r_done;
  assign sent_cnt = r_sent;
  assign mem_EN = w_issue;
  assign mem_A = r_addr;
  assign ss_tvalid = !w_empty;
  assign ss_tdata = w_empty ? '0 : w_head;
  assign ss_tlast = ss_tvalid && (r_sent == r_len - 32'd1);
  fir_stream_fifo #(.DW(pDATA_WIDTH), .DEPTH(BUF_DEPTH)) u_fifo (
    .clk(axis_clk),
    .rst(axis_rst),
    .i_push(w_push),
    .i_din(mem_Do),
    .i_pop(w_pop),
    .o_dout(w_head),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_count(w_cnt)
  );
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_state <= ST_IDLE;
      r_len <= '0;
      r_rd_cnt <= '0;
      r_sent <= '0;
      r_addr <= '0;
      r_inflight <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_done <= 1'b0;
      if (w_pop) r_sent <= r_sent + 32'd1;
      if (w_issue) begin
        r_addr <= r_addr + pADDR_WIDTH'(BYTES_PER_SAMPLE);
        r_rd_cnt <= r_rd_cnt + 32'd1;
      end
      case (r_state)
        ST_IDLE: if (start) begin
          r_len <= length;
          r_addr <= base_addr;
          r_rd_cnt <= '0;
          r_sent <= '0;
          r_state <= (length == '0) ? ST_IDLE : ST_RUN;
          r_done <= length == '0;
        end
        ST_RUN: if (w_issue && r_rd_cnt == r_len - 32'd1) r_state <= ST_FLUSH;
        ST_FLUSH: if (w_pop && ss_tlast) begin
          r_state <= ST_IDLE;
          r_done <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
